// File: rtl/axi4_sub_mem_if.sv
// AXI4 single-beat bus bundle between a manager and the axi4_sub_mem responder.
// Handshake rule on every channel: a transfer happens at the rising edge where valid and ready are both 1.
// A source holds valid and its payload until that edge. ready may assert before valid does.
interface axi4_sub_mem_if #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [2:0]           awprot;
    logic [DATAWIDTH-1:0] wdata;
    logic                 wvalid;
    logic                 wready;
    logic                 wlast;
    logic                 bvalid;
    logic                 bready;
    logic [1:0]           bresp;
    logic [ADDRWIDTH-1:0] araddr;
    logic                 arvalid;
    logic                 arready;
    logic [2:0]           arprot;
    logic [DATAWIDTH-1:0] rdata;
    logic                 rvalid;
    logic                 rready;
    logic [1:0]           rresp;

    modport master (
        output awaddr, awvalid, awprot, wdata, wvalid, wlast, bready,
               araddr, arvalid, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );

    modport slave (
        input  awaddr, awvalid, awprot, wdata, wvalid, wlast, bready,
               araddr, arvalid, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
endinterface

// File: rtl/axi4_sub_mem.sv
// Single-beat AXI4 responder memory with programmable ready delay and read latency.
// One outstanding write and one outstanding read; the two paths run independently.
module axi4_sub_mem #(
    parameter int ADDRWIDTH    = 32,
    parameter int DATAWIDTH    = 32,
    parameter int MEMDEPTHLOG2 = 10,
    parameter int READYDELAY   = 0,
    parameter int RDLATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 nreset,
    axi4_sub_mem_if.slave        bus,
    output logic [1:0]           read_state
);
    localparam int B     = $clog2(DATAWIDTH / 8);
    localparam int DEPTH = 1 << MEMDEPTHLOG2;
    localparam int TOP   = MEMDEPTHLOG2 + B;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rstate_t;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic unused_ok;
    assign unused_ok = ^{bus.awprot, bus.wlast, bus.arprot};

    // Incoming address decode: low byte-lane bits are ignored, any bit above the RAM is out of range.
    logic [MEMDEPTHLOG2-1:0] aw_idx_in, ar_idx_in;
    logic                    aw_oor_in, ar_oor_in;
    assign aw_idx_in = bus.awaddr[TOP-1:B];
    assign ar_idx_in = bus.araddr[TOP-1:B];
    assign aw_oor_in = |(bus.awaddr >> TOP);
    assign ar_oor_in = |(bus.araddr >> TOP);

    // ---------------- write path ----------------
    logic                    aw_cap, w_cap, aw_oor;
    logic [MEMDEPTHLOG2-1:0] aw_idx;
    logic [DATAWIDTH-1:0]    w_buf;
    logic [3:0]              aw_cnt, w_cnt;
    logic                    aw_elig, w_elig, aw_hs, w_hs, commit;
    logic [MEMDEPTHLOG2-1:0] c_idx;
    logic                    c_oor;
    logic [DATAWIDTH-1:0]    c_data;

    assign aw_elig     = !aw_cap && !bus.bvalid;
    assign w_elig      = !w_cap && !bus.bvalid;
    assign bus.awready = nreset && aw_elig && (aw_cnt == 4'(READYDELAY));
    assign bus.wready  = nreset && w_elig && (w_cnt == 4'(READYDELAY));
    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready;

    // The write commits at the edge where the second of the two channels lands.
    assign commit = (aw_hs || aw_cap) && (w_hs || w_cap);
    assign c_idx  = aw_cap ? aw_idx : aw_idx_in;
    assign c_oor  = aw_cap ? aw_oor : aw_oor_in;
    assign c_data = w_cap ? w_buf : bus.wdata;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            aw_cap     <= 1'b0;
            w_cap      <= 1'b0;
            aw_oor     <= 1'b0;
            aw_idx     <= '0;
            w_buf      <= '0;
            aw_cnt     <= '0;
            w_cnt      <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
        end else begin
            aw_cnt <= (bus.awvalid && aw_elig && !bus.awready) ? aw_cnt + 4'd1 : 4'd0;
            w_cnt  <= (bus.wvalid && w_elig && !bus.wready) ? w_cnt + 4'd1 : 4'd0;
            if (commit) begin
                aw_cap     <= 1'b0;
                w_cap      <= 1'b0;
                bus.bvalid <= 1'b1;
                bus.bresp  <= c_oor ? 2'b10 : 2'b00;
            end else begin
                if (aw_hs) begin
                    aw_cap <= 1'b1;
                    aw_idx <= aw_idx_in;
                    aw_oor <= aw_oor_in;
                end
                if (w_hs) begin
                    w_cap <= 1'b1;
                    w_buf <= bus.wdata;
                end
                if (bus.bvalid && bus.bready) begin
                    bus.bvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !c_oor) begin
            mem[c_idx] <= c_data;
        end
    end

    // ---------------- read path ----------------
    rstate_t                 state, state_next;
    logic [3:0]              ar_cnt, lat_cnt;
    logic [MEMDEPTHLOG2-1:0] rd_idx, s_idx;
    logic                    rd_oor, s_oor, ar_hs, sample, fwd;

    assign bus.arready = nreset && (state == R_IDLE) && (ar_cnt == 4'(READYDELAY));
    assign ar_hs       = bus.arvalid && bus.arready;
    assign bus.rvalid  = (state == R_RESP);
    assign read_state  = state;

    // With a latency of one the RAM is sampled at the AR edge itself, from the live address.
    assign s_idx = (state == R_IDLE) ? ar_idx_in : rd_idx;
    assign s_oor = (state == R_IDLE) ? ar_oor_in : rd_oor;
    assign fwd   = commit && !c_oor && (c_idx == s_idx);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            R_IDLE: begin
                if (ar_hs) begin
                    if (RDLATENCY <= 1) begin
                        state_next = R_RESP;
                        sample     = 1'b1;
                    end else begin
                        state_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt <= 4'd1) begin
                    state_next = R_RESP;
                    sample     = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ar_cnt    <= '0;
            lat_cnt   <= '0;
            rd_idx    <= '0;
            rd_oor    <= 1'b0;
            bus.rdata <= '0;
            bus.rresp <= 2'b00;
        end else begin
            ar_cnt <= (bus.arvalid && (state == R_IDLE) && !bus.arready) ? ar_cnt + 4'd1 : 4'd0;
            if (ar_hs) begin
                rd_idx  <= ar_idx_in;
                rd_oor  <= ar_oor_in;
                lat_cnt <= 4'(RDLATENCY - 1);
            end else if (state == R_WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (sample) begin
                bus.rresp <= s_oor ? 2'b10 : 2'b00;
                if (s_oor) begin
                    bus.rdata <= '0;
                end else if (fwd) begin
                    bus.rdata <= c_data;
                end else begin
                    bus.rdata <= mem[s_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4_sub_mem.sv
// Directed bench for axi4_sub_mem: a zero-delay/latency-1 instance and a delay-3/latency-4 instance.
// Vector table for single transactions plus hand-written multi-cycle sequences.
module tb_axi4_sub_mem;
    logic clk;
    logic nreset;
    logic [1:0] rs0, rs1;
    int compared;
    int mismatched;

    axi4_sub_mem_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus0();
    axi4_sub_mem_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus1();

    axi4_sub_mem #(.ADDRWIDTH(32), .DATAWIDTH(32), .MEMDEPTHLOG2(10),
                   .READYDELAY(0), .RDLATENCY(1))
        u_dut0 (.clk(clk), .nreset(nreset), .bus(bus0), .read_state(rs0));

    axi4_sub_mem #(.ADDRWIDTH(32), .DATAWIDTH(32), .MEMDEPTHLOG2(10),
                   .READYDELAY(3), .RDLATENCY(4))
        u_dut1 (.clk(clk), .nreset(nreset), .bus(bus1), .read_state(rs1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [1:0]  exp_bresp;
        logic [31:0] rd_addr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-delay instance: AW and W in one cycle, response checked the very next cycle.
    task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
        bus0.awaddr = a; bus0.wdata = d; bus0.awvalid = 1'b1; bus0.wvalid = 1'b1; bus0.bready = 1'b1;
        chk("wr0_ready", {30'd0, bus0.awready, bus0.wready}, 32'd3);
        step();
        bus0.awvalid = 1'b0; bus0.wvalid = 1'b0;
        chk("wr0_bvalid", {31'd0, bus0.bvalid}, 32'd1);
        chk("wr0_bresp", {30'd0, bus0.bresp}, {30'd0, er});
        step();
        chk("wr0_bvalid_drop", {31'd0, bus0.bvalid}, 32'd0);
    endtask

    task automatic rd0(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        bus0.araddr = a; bus0.arvalid = 1'b1; bus0.rready = 1'b1;
        chk("rd0_arready", {31'd0, bus0.arready}, 32'd1);
        step();
        bus0.arvalid = 1'b0;
        chk("rd0_rvalid", {31'd0, bus0.rvalid}, 32'd1);
        chk("rd0_rdata", bus0.rdata, ed);
        chk("rd0_rresp", {30'd0, bus0.rresp}, {30'd0, er});
        step();
        chk("rd0_rvalid_drop", {31'd0, bus0.rvalid}, 32'd0);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
        logic aw_fire, w_fire;
        int n;
        bus1.awaddr = a; bus1.wdata = d; bus1.awvalid = 1'b1; bus1.wvalid = 1'b1; bus1.bready = 1'b1;
        n = 0;
        while ((bus1.awvalid || bus1.wvalid) && n < 20) begin
            aw_fire = bus1.awready;
            w_fire  = bus1.wready;
            step();
            if (aw_fire) bus1.awvalid = 1'b0;
            if (w_fire) bus1.wvalid = 1'b0;
            n++;
        end
        chk("wr1_hs_timeout", {30'd0, bus1.awvalid, bus1.wvalid}, 32'd0);
        bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
        chk("wr1_bvalid", {31'd0, bus1.bvalid}, 32'd1);
        chk("wr1_bresp", {30'd0, bus1.bresp}, {30'd0, er});
        step();
        chk("wr1_bvalid_drop", {31'd0, bus1.bvalid}, 32'd0);
    endtask

    task automatic rd1(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        int lat;
        bus1.araddr = a; bus1.arvalid = 1'b1; bus1.rready = 1'b1;
        n = 0;
        while (!bus1.arready && n < 20) begin
            step();
            n++;
        end
        chk("rd1_ar_timeout", {31'd0, bus1.arready}, 32'd1);
        step();
        bus1.arvalid = 1'b0;
        lat = 1;
        while (!bus1.rvalid && lat < 20) begin
            step();
            lat++;
        end
        chk("rd1_latency", lat, 32'd4);
        chk("rd1_rdata", bus1.rdata, ed);
        chk("rd1_rresp", {30'd0, bus1.rresp}, {30'd0, er});
        step();
        chk("rd1_rvalid_drop", {31'd0, bus1.rvalid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        compared   = 0;
        mismatched = 0;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h0000_0FFC, 32'h0BAD_F00D, 2'b00, 32'h0000_0FFF, 32'h0BAD_F00D, 2'b00};
        vecs[2] = '{32'h0000_0000, 32'h1111_1111, 2'b00, 32'h0000_0002, 32'h1111_1111, 2'b00};
        vecs[3] = '{32'h0000_1000, 32'hFFFF_FFFF, 2'b10, 32'h0000_1000, 32'h0000_0000, 2'b10};
        vecs[4] = '{32'h8000_0004, 32'h2222_2222, 2'b10, 32'h0000_0000, 32'h1111_1111, 2'b00};
        vecs[5] = '{32'h0000_0014, 32'h5A5A_5A5A, 2'b00, 32'h0000_0014, 32'h5A5A_5A5A, 2'b00};

        bus0.awaddr = '0; bus0.awvalid = 0; bus0.awprot = '0; bus0.wdata = '0; bus0.wvalid = 0;
        bus0.wlast = 1; bus0.bready = 0; bus0.araddr = '0; bus0.arvalid = 0; bus0.arprot = '0;
        bus0.rready = 0;
        bus1.awaddr = '0; bus1.awvalid = 0; bus1.awprot = '0; bus1.wdata = '0; bus1.wvalid = 0;
        bus1.wlast = 1; bus1.bready = 0; bus1.araddr = '0; bus1.arvalid = 0; bus1.arprot = '0;
        bus1.rready = 0;
        nreset = 1'b0;

        // Reset state.
        #3;
        chk("rst_ready0", {29'd0, bus0.awready, bus0.wready, bus0.arready}, 32'd0);
        chk("rst_valid0", {30'd0, bus0.bvalid, bus0.rvalid}, 32'd0);
        chk("rst_rdata0", bus0.rdata, 32'd0);
        chk("rst_resp0", {28'd0, bus0.bresp, bus0.rresp}, 32'd0);
        chk("rst_valid1", {27'd0, bus1.awready, bus1.wready, bus1.arready, bus1.bvalid, bus1.rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        #3 nreset = 1'b1;
        step();
        chk("post_rst_ready0", {29'd0, bus0.awready, bus0.wready, bus0.arready}, 32'd7);

        // Table: write then read back on the zero-delay instance.
        for (int i = 0; i < 6; i++) begin
            wr0(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].exp_bresp);
            rd0(vecs[i].rd_addr, vecs[i].exp_rdata, vecs[i].exp_rresp);
        end

        // W before AW.
        bus0.wdata = 32'h1234_5678; bus0.wvalid = 1'b1; bus0.bready = 1'b1;
        step();
        bus0.wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("wfirst_wready_low", {31'd0, bus0.wready}, 32'd0);
            chk("wfirst_awready_high", {31'd0, bus0.awready}, 32'd1);
            chk("wfirst_no_bvalid", {31'd0, bus0.bvalid}, 32'd0);
            if (c == 3) begin
                bus0.awaddr = 32'h20; bus0.awvalid = 1'b1;
            end
            step();
        end
        bus0.awvalid = 1'b0;
        chk("wfirst_bvalid", {31'd0, bus0.bvalid}, 32'd1);
        chk("wfirst_bresp", {30'd0, bus0.bresp}, 32'd0);
        step();
        rd0(32'h20, 32'h1234_5678, 2'b00);

        // Back-pressure: write 0x30 and read 0x10 together, both responses stalled 5 cycles.
        bus0.awaddr = 32'h30; bus0.wdata = 32'hCAFE_F00D; bus0.awvalid = 1'b1; bus0.wvalid = 1'b1;
        bus0.bready = 1'b0; bus0.araddr = 32'h10; bus0.arvalid = 1'b1; bus0.rready = 1'b0;
        step();
        bus0.awvalid = 1'b0; bus0.wvalid = 1'b0; bus0.arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_bvalid", {31'd0, bus0.bvalid}, 32'd1);
            chk("bp_bresp", {30'd0, bus0.bresp}, 32'd0);
            chk("bp_rvalid", {31'd0, bus0.rvalid}, 32'd1);
            chk("bp_rdata", bus0.rdata, 32'hDEAD_BEEF);
            chk("bp_rresp", {30'd0, bus0.rresp}, 32'd0);
            chk("bp_readies", {29'd0, bus0.awready, bus0.wready, bus0.arready}, 32'd0);
            step();
        end
        bus0.bready = 1'b1; bus0.rready = 1'b1;
        step();
        chk("bp_release_valids", {30'd0, bus0.bvalid, bus0.rvalid}, 32'd0);
        chk("bp_rdata_held", bus0.rdata, 32'hDEAD_BEEF);
        step();
        chk("bp_single_resp", {30'd0, bus0.bvalid, bus0.rvalid}, 32'd0);
        chk("bp_readies_back", {29'd0, bus0.awready, bus0.wready, bus0.arready}, 32'd7);
        rd0(32'h30, 32'hCAFE_F00D, 2'b00);

        // Write commit and read sample on the same edge, same word: forwarded data.
        bus0.awaddr = 32'h40; bus0.wdata = 32'h600D_CAFE; bus0.awvalid = 1'b1; bus0.wvalid = 1'b1;
        bus0.araddr = 32'h40; bus0.arvalid = 1'b1;
        step();
        bus0.awvalid = 1'b0; bus0.wvalid = 1'b0; bus0.arvalid = 1'b0;
        chk("fwd_bvalid", {31'd0, bus0.bvalid}, 32'd1);
        chk("fwd_rvalid", {31'd0, bus0.rvalid}, 32'd1);
        chk("fwd_rdata", bus0.rdata, 32'h600D_CAFE);
        step();

        // Delayed instance: readies on the 4th valid cycle, rvalid 4 cycles after AR.
        bus1.awaddr = 32'h8; bus1.wdata = 32'h7766_5544; bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
        bus1.araddr = 32'h8; bus1.arvalid = 1'b1; bus1.bready = 1'b1; bus1.rready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("dly_ready_low", {29'd0, bus1.awready, bus1.wready, bus1.arready}, 32'd0);
            step();
        end
        chk("dly_ready_4th", {29'd0, bus1.awready, bus1.wready, bus1.arready}, 32'd7);
        step();
        bus1.awvalid = 1'b0; bus1.wvalid = 1'b0; bus1.arvalid = 1'b0;
        chk("dly_bvalid", {31'd0, bus1.bvalid}, 32'd1);
        chk("dly_state_wait", {30'd0, rs1}, 32'd1);
        for (int c = 1; c < 4; c++) begin
            chk("dly_rvalid_low", {31'd0, bus1.rvalid}, 32'd0);
            step();
        end
        chk("dly_rvalid", {31'd0, bus1.rvalid}, 32'd1);
        chk("dly_rdata", bus1.rdata, 32'h7766_5544);
        step();

        // Dropping valid restarts the delay count.
        bus1.araddr = 32'h8; bus1.arvalid = 1'b1;
        step();
        step();
        bus1.arvalid = 1'b0;
        step();
        bus1.arvalid = 1'b1;
        step();
        step();
        chk("dly_restart_low", {31'd0, bus1.arready}, 32'd0);
        step();
        chk("dly_restart_high", {31'd0, bus1.arready}, 32'd1);
        step();
        bus1.arvalid = 1'b0;
        repeat (4) step();
        chk("dly_restart_rdata", bus1.rdata, 32'h7766_5544);

        // Reset with a read in R_WAIT and only W captured.
        bus1.wdata = 32'hBAD0_BAD0; bus1.wvalid = 1'b1; bus1.araddr = 32'hC; bus1.arvalid = 1'b1;
        repeat (4) step();
        bus1.wvalid = 1'b0; bus1.arvalid = 1'b0;
        chk("mid_state_wait", {30'd0, rs1}, 32'd1);
        chk("mid_wready_low", {31'd0, bus1.wready}, 32'd0);
        #2 nreset = 1'b0;
        #1;
        chk("arst_readies", {29'd0, bus1.awready, bus1.wready, bus1.arready}, 32'd0);
        chk("arst_valids", {30'd0, bus1.bvalid, bus1.rvalid}, 32'd0);
        chk("arst_data", bus1.rdata, 32'd0);
        chk("arst_resp", {28'd0, bus1.bresp, bus1.rresp}, 32'd0);
        chk("arst_state", {30'd0, rs1}, 32'd0);
        repeat (2) @(posedge clk);
        #3 nreset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen = seen | bus1.bvalid | bus1.rvalid;
        end
        chk("arst_no_resp", {31'd0, seen}, 32'd0);
        wr1(32'hC, 32'h0F0F_0F0F, 2'b00);
        rd1(32'hC, 32'h0F0F_0F0F, 2'b00);
        wr1(32'h1000, 32'h3333_3333, 2'b10);
        rd1(32'h1000, 32'h0000_0000, 2'b10);
        rd1(32'h8, 32'h7766_5544, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
